// File: rtl/uart_pkg.sv
// Shared types and constants for the UART shift datapath.
// Included by the shift register and by the framing FSMs.
package uart_pkg;

  typedef enum logic [1:0] {
    SM_HOLD = 2'b00,
    SM_LOAD = 2'b01,
    SM_SHR  = 2'b10,
    SM_SHL  = 2'b11
  } shift_mode_t;

  localparam logic UART_IDLE = 1'b1;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with a registered "maximum reached" flag.
// The flag is high exactly while the count equals max_val.
module sat_cnt #(
  parameter int max_val = 10,
  parameter int cnt_w   = $clog2(max_val + 1)
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             clr,
  input  logic             inc,
  output logic [cnt_w-1:0] cnt,
  output logic             max_hit
);

  localparam logic [cnt_w-1:0] MAX_V = cnt_w'(max_val);

  // max_hit tracks the next count so it rises on the edge where cnt reaches max_val
  always_ff @(posedge clk) begin
    if (RST) begin
      cnt     <= '0;
      max_hit <= 1'b0;
    end else if (clr) begin
      cnt     <= '0;
      max_hit <= 1'b0;
    end else if (inc) begin
      if (cnt < MAX_V) begin
        cnt     <= cnt + 1'b1;
        max_hit <= ((cnt + 1'b1) == MAX_V);
      end else begin
        max_hit <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_reg_ctl.sv
// Universal shift register for the UART TX serialiser and RX deserialiser,
// with a saturating count of shifts since the last load.
module shift_reg_ctl
  import uart_pkg::*;
#(
  parameter int                numBit  = 10,
  parameter logic [numBit-1:0] RST_VAL = {numBit{UART_IDLE}},
  parameter int                CNT_W   = $clog2(numBit + 1)
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              en,
  input  shift_mode_t       mode,
  input  logic [numBit-1:0] d,
  input  logic              sin,
  output logic [numBit-1:0] q,
  output logic              sout_r,
  output logic              sout_l,
  output logic [CNT_W-1:0]  cnt,
  output logic              done
);

  logic cnt_clr;
  logic cnt_inc;

  // Anything other than a recognised mode (including unknowns) acts as HOLD
  always_comb begin
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (en) begin
      case (mode)
        SM_LOAD: cnt_clr = 1'b1;
        SM_SHR:  cnt_inc = 1'b1;
        SM_SHL:  cnt_inc = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      q <= RST_VAL;
    end else if (en) begin
      case (mode)
        SM_LOAD: q <= d;
        SM_SHR:  q <= {sin, q[numBit-1:1]};
        SM_SHL:  q <= {q[numBit-2:0], sin};
        default: q <= q;
      endcase
    end
  end

  assign sout_r = q[0];
  assign sout_l = q[numBit-1];

  sat_cnt #(
    .max_val(numBit),
    .cnt_w  (CNT_W)
  ) u_sat_cnt (
    .clk    (clk),
    .RST    (RST),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .cnt    (cnt),
    .max_hit(done)
  );

endmodule

// File: tb/tb_shift_reg_ctl.sv
// Scoreboard bench for shift_reg_ctl: each driven edge queues its expected state,
// a monitor compares after every rising edge.
module tb_shift_reg_ctl;
  import uart_pkg::*;

  logic        clk;
  logic        RST;
  logic        en;
  shift_mode_t mode;
  logic [9:0]  d;
  logic        sin;
  logic [9:0]  q;
  logic        sout_r;
  logic        sout_l;
  logic [3:0]  cnt;
  logic        done;

  typedef struct {
    logic [9:0] q;
    logic [3:0] cnt;
    logic       done;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  shift_reg_ctl dut (
    .clk   (clk),
    .RST   (RST),
    .en    (en),
    .mode  (mode),
    .d     (d),
    .sin   (sin),
    .q     (q),
    .sout_r(sout_r),
    .sout_l(sout_l),
    .cnt   (cnt),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one queued expectation is consumed per rising edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({e.name, ".q"},      q,               e.q);
      checkOutput({e.name, ".cnt"},    {6'd0, cnt},     {6'd0, e.cnt});
      checkOutput({e.name, ".done"},   {9'd0, done},    {9'd0, e.done});
      checkOutput({e.name, ".sout_r"}, {9'd0, sout_r},  {9'd0, e.q[0]});
      checkOutput({e.name, ".sout_l"}, {9'd0, sout_l},  {9'd0, e.q[9]});
    end
  end

  task automatic applyStimulus(input logic r, input logic e, input shift_mode_t m,
                               input logic [9:0] dd, input logic s,
                               input logic [9:0] eq, input logic [3:0] ec,
                               input logic ed, input string name);
    exp_t x;
    @(negedge clk);
    RST  = r;
    en   = e;
    mode = m;
    d    = dd;
    sin  = s;
    x.q = eq; x.cnt = ec; x.done = ed; x.name = name;
    sb.push_back(x);
  endtask

  logic [9:0] shr_exp [10] = '{10'h352, 10'h3A9, 10'h3D4, 10'h3EA, 10'h3F5,
                               10'h3FA, 10'h3FD, 10'h3FE, 10'h3FF, 10'h3FF};
  logic       shl_sin [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [9:0] shl_exp [10] = '{10'h001, 10'h003, 10'h006, 10'h00C, 10'h019,
                               10'h032, 10'h065, 10'h0CA, 10'h195, 10'h32B};
  logic [9:0] mid_exp [4]  = '{10'h078, 10'h03C, 10'h01E, 10'h00F};

  initial begin
    int wait_cycles;
    RST = 1'b1; en = 1'b0; mode = SM_SHR; d = '0; sin = 1'b0;

    for (int i = 0; i < 3; i++)
      applyStimulus(1, 0, SM_SHR, 10'h000, 0, 10'h3FF, 4'd0, 0, "reset");

    for (int i = 0; i < 4; i++)
      applyStimulus(0, 0, SM_LOAD, 10'h155, 0, 10'h3FF, 4'd0, 0, "en_gate");
    applyStimulus(0, 1, SM_LOAD, 10'h155, 0, 10'h155, 4'd0, 0, "en_load");

    applyStimulus(0, 1, SM_LOAD, 10'h2A5, 1, 10'h2A5, 4'd0, 0, "ser_load");
    for (int i = 0; i < 10; i++)
      applyStimulus(0, 1, SM_SHR, 10'h000, 1, shr_exp[i], 4'(i + 1), (i == 9), "ser_shr");
    applyStimulus(0, 1, SM_SHR, 10'h000, 1, 10'h3FF, 4'd10, 1, "ser_sat");
    applyStimulus(0, 0, SM_SHL, 10'h000, 0, 10'h3FF, 4'd10, 1, "sat_en_off");

    applyStimulus(0, 1, SM_LOAD, 10'h000, 0, 10'h000, 4'd0, 0, "des_load");
    for (int i = 0; i < 10; i++)
      applyStimulus(0, 1, SM_SHL, 10'h000, shl_sin[i], shl_exp[i], 4'(i + 1), (i == 9), "des_shl");

    applyStimulus(0, 1, SM_LOAD, 10'h3C3, 0, 10'h3C3, 4'd0, 0, "sat_reload");
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 1, SM_HOLD, 10'h0AA, 1, 10'h3C3, 4'd0, 0, "hold");

    applyStimulus(0, 1, SM_LOAD, 10'h0F0, 0, 10'h0F0, 4'd0, 0, "mid_load");
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1, SM_SHR, 10'h000, 0, mid_exp[i], 4'(i + 1), 0, "mid_shr");
    applyStimulus(1, 1, SM_SHR, 10'h000, 0, 10'h3FF, 4'd0, 0, "mid_reset");
    applyStimulus(0, 1, SM_LOAD, 10'h001, 0, 10'h001, 4'd0, 0, "mid_reload");

    applyStimulus(0, 1, SM_SHL, 10'h000, 0, 10'h002, 4'd1, 0, "mix_shl");
    applyStimulus(0, 1, SM_SHR, 10'h000, 1, 10'h201, 4'd2, 0, "mix_shr");
    applyStimulus(0, 0, SM_HOLD, 10'h000, 0, 10'h201, 4'd2, 0, "idle");

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
